serial_add_ctrl: RTL

Bit-serial addition controller that time-shares a single one-bit `fulladder` cell to add two WIDTH-bit operands. It works LSB-first, one bit per clock, and keeps the carry in a register between bits. The block sits between a requester (start/done handshake) and an external `fulladder` instance, which it drives through its `fa_*` ports. It replaces a WIDTH-cell ripple adder where area matters more than latency.

---
 rtl/serial_add_ctrl_if.sv | 13 +
 rtl/serial_add_ctrl.sv | 89 ++++++++
 2 files changed

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: start/done requester handshake carrying operands and the registered result.
interface serial_add_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin_init;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    modport master (output start, a, b, cin_init, input busy, done, sum, cout);
    modport slave (input start, a, b, cin_init, output busy, done, sum, cout);
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: LSB-first bit-serial adder that time-shares one external fulladder cell,
// holding the carry in c_q between bits.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    serial_add_if.slave bus,
    output logic     fa_x,
    output logic     fa_y,
    output logic     fa_cin,
    input  logic     fa_result,
    input  logic     fa_cout
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_nx;
    logic             c_q;
    logic [CW-1:0]    cnt;
    logic             load;
    logic             last;

    assign last = cnt == CW'(WIDTH - 1);
    // shift form keeps WIDTH=1 legal where a [WIDTH-1:1] slice would not be
    assign s_nx = (s_sh >> 1) | (WIDTH'(fa_result) << (WIDTH - 1));

    assign fa_x     = state == RUN ? a_sh[0] : 1'b0;
    assign fa_y     = state == RUN ? b_sh[0] : 1'b0;
    assign fa_cin   = state == RUN ? c_q : 1'b0;
    assign bus.busy = state == RUN;
    assign bus.done = state == DONE;

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE: begin
                load     = bus.start;
                state_nx = bus.start ? RUN : IDLE;
            end
            RUN:     state_nx = last ? DONE : RUN;
            DONE: begin
                load     = bus.start;
                state_nx = bus.start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            s_sh     <= '0;
            c_q      <= 1'b0;
            cnt      <= '0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
        end else if (load) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            s_sh <= '0;
            c_q  <= bus.cin_init;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            s_sh <= s_nx;
            c_q  <= fa_cout;
            cnt  <= cnt + 1'b1;
            if (last) begin
                bus.sum  <= s_nx;
                bus.cout <= fa_cout;
            end
        end
    end
endmodule
